// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding for the memory request/response block
package mem_pkg;

  typedef enum logic {
    MEM_INIT  = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - small in-order response buffer with registered storage
module mem_rsp_fifo #(
  parameter int Depth = 2,
  parameter int Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_tvalid,
  input  logic [Width-1:0] in_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [Width-1:0] out_tdata
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] store_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push, pop;

  assign pop        = out_tvalid && out_tready;
  assign push       = in_tvalid && ((cnt_q != FullCnt) || pop);
  assign out_tvalid = (cnt_q != '0);
  assign out_tdata  = store_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      store_q[wr_ptr_q] <= in_tdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: rtl/mem_req_rsp.sv
// rtl/mem_req_rsp.sv - cleared word memory with valid/ready request and response ports
// Optional: define MEM_REQ_RSP_ERR_EN to flag out-of-range requests on rsp_err_o.
module mem_req_rsp
  import mem_pkg::*;
#(
  parameter  int ElemWidth = 32,
  parameter  int Depth     = 256,
  parameter  int RdLatency = 1,
  localparam int AddrWidth = $clog2(Depth),
  localparam int StrbWidth = ElemWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [ElemWidth-1:0] req_wdata_i,
  input  logic [StrbWidth-1:0] req_strb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ElemWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 init_done_o
);

  localparam int CntW = $clog2(RdLatency + 2);
  localparam logic [CntW-1:0]      MaxOut   = CntW'(RdLatency + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  mem_state_e           state_q, state_d;
  logic [AddrWidth-1:0] sweep_q;
  logic [CntW-1:0]      outst_q;
  logic [ElemWidth-1:0] mem_q [Depth];

  logic                 accept, in_range, wr_en, rsp_pop, acc_err, push_valid;
  logic [ElemWidth-1:0] rd_word, rd_resp;
  logic [ElemWidth:0]   acc_data, push_data, head;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= MEM_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_done_o = 1'b0;
    req_ready_o = 1'b0;
    case (state_q)
      MEM_INIT: begin
        if (sweep_q == LastAddr) begin
          state_d = MEM_READY;
        end
      end
      MEM_READY: begin
        init_done_o = 1'b1;
        req_ready_o = (outst_q < MaxOut);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sweep_q <= '0;
    end else if (state_q == MEM_INIT) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  // Power-of-two depths cannot encode an out-of-range address.
  generate
    if ((1 << AddrWidth) == Depth) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (req_addr_i <= LastAddr);
    end
  endgenerate

  assign accept   = req_valid_i && req_ready_o;
  assign wr_en    = accept && req_we_i && in_range;
  assign rd_word  = in_range ? mem_q[req_addr_i] : '0;
  assign rd_resp  = req_we_i ? '0 : rd_word;
  assign acc_data = {acc_err, rd_resp};

`ifdef MEM_REQ_RSP_ERR_EN
  assign acc_err = ~in_range;
`else
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (state_q == MEM_INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (req_strb_i[b]) begin
          mem_q[req_addr_i][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance; the remaining latency is pure delay.
  generate
    if (RdLatency == 1) begin : g_lat1
      assign push_valid = accept;
      assign push_data  = acc_data;
    end else begin : g_pipe
      localparam int Stages = RdLatency - 1;
      logic [Stages-1:0] pv_q;
      logic [ElemWidth:0] pd_q [Stages];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= accept;
          for (int i = 1; i < Stages; i++) begin
            pv_q[i] <= pv_q[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        pd_q[0] <= acc_data;
        for (int i = 1; i < Stages; i++) begin
          pd_q[i] <= pd_q[i-1];
        end
      end

      assign push_valid = pv_q[Stages-1];
      assign push_data  = pd_q[Stages-1];
    end
  endgenerate

  mem_rsp_fifo #(
    .Depth(RdLatency + 1),
    .Width(ElemWidth + 1)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_tvalid (push_valid),
    .in_tdata  (push_data),
    .out_tvalid(rsp_valid_o),
    .out_tready(rsp_ready_i),
    .out_tdata (head)
  );

  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? head[ElemWidth-1:0] : '0;
  assign rsp_err_o   = rsp_valid_o & head[ElemWidth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_q + CntW'(accept) - CntW'(rsp_pop);
    end
  end

endmodule
